// File: rtl/subsys_clkrst_pkg.sv
// Shared types and default sizing for the timer-subsystem clock/reset controller.
package subsys_clkrst_pkg;

  // Watchdog local-reset sequencer states.
  typedef enum logic [0:0] {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_e;

  // Default widths and hold length.
  localparam int unsigned DefDivW    = 8;
  localparam int unsigned DefRstHold = 16;
  localparam int unsigned DefCntW    = 8;

  // Width needed to hold a down-counter loaded with hold_len-1 (never zero).
  function automatic int unsigned hold_cnt_width(input int unsigned hold_len);
    return (hold_len > 1) ? $clog2(hold_len) : 1;
  endfunction

endpackage

// File: rtl/clken_div.sv
// Programmable clock-enable divider: one registered pulse every div+1 enabled cycles.
module clken_div
  import subsys_clkrst_pkg::*;
#(
  parameter int unsigned DIV_W = DefDivW
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             en,
  input  logic             force_idle,
  input  logic [DIV_W-1:0] div,
  output logic             clken
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clken_q, clken_d;
  logic             active;

  assign active = en & ~force_idle;

  // Next count and pulse; the >= compare lets a lowered div fire on the next cycle.
  always_comb begin
    cnt_d   = '0;
    clken_d = 1'b0;
    if (active) begin
      if (cnt_q >= div) begin
        clken_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and output pulse registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q   <= '0;
      clken_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clken_q <= clken_d;
    end
  end

  assign clken = clken_q;

endmodule

// File: rtl/subsys_clkrst_ctrl.sv
// Clock-enable generation and watchdog local-reset sequencing for the timer subsystem.
module subsys_clkrst_ctrl
  import subsys_clkrst_pkg::*;
#(
  parameter int unsigned DIV_W    = DefDivW,
  parameter int unsigned RST_HOLD = DefRstHold,
  parameter int unsigned CNT_W    = DefCntW
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             dt_en1,
  input  logic             dt_en2,
  input  logic             wd_en,
  input  logic [DIV_W-1:0] dt_div1,
  input  logic [DIV_W-1:0] dt_div2,
  input  logic [DIV_W-1:0] wd_div,
  input  logic             watchdog_res,
  output logic             dualtimer_clken1,
  output logic             dualtimer_clken2,
  output logic             watchdog_clken,
  output logic             watchdog_rstn,
  output logic [CNT_W-1:0] wd_rst_cnt,
  output logic             wd_rst_busy
);

  localparam int unsigned          HoldW    = hold_cnt_width(RST_HOLD);
  localparam logic [HoldW-1:0]     HoldLoad = HoldW'(RST_HOLD - 1);

  rst_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             rstn_q, busy_q;
  logic             res_q, res_prev_q;
  logic             res_rise;
  logic             wd_idle;

  // Dualtimer channel dividers.
  clken_div #(
    .DIV_W (DIV_W)
  ) u_div_dt1 (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .en         (dt_en1),
    .force_idle (1'b0),
    .div        (dt_div1),
    .clken      (dualtimer_clken1)
  );

  clken_div #(
    .DIV_W (DIV_W)
  ) u_div_dt2 (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .en         (dt_en2),
    .force_idle (1'b0),
    .div        (dt_div2),
    .clken      (dualtimer_clken2)
  );

  // The watchdog must not tick while it is held in its local reset.
  assign wd_idle = (state_q != RUN);

  clken_div #(
    .DIV_W (DIV_W)
  ) u_div_wd (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .en         (wd_en),
    .force_idle (wd_idle),
    .div        (wd_div),
    .clken      (watchdog_clken)
  );

  // Capture watchdog_res, then compare against its previous sample. Both reset high so a
  // request already asserted out of reset is not mistaken for a new edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      res_q      <= 1'b1;
      res_prev_q <= 1'b1;
    end else begin
      res_q      <= watchdog_res;
      res_prev_q <= res_q;
    end
  end

  assign res_rise = res_q & ~res_prev_q;

  // Reset sequencer next state, hold countdown and saturating event count.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rst_cnt_d = rst_cnt_q;
    unique case (state_q)
      HOLD: begin
        if (hold_q == '0) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      RUN: begin
        if (res_rise) begin
          state_d = HOLD;
          hold_d  = HoldLoad;
          if (rst_cnt_q != '1) begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = HOLD;
        hold_d  = HoldLoad;
      end
    endcase
  end

  // Sequencer state plus registered copies of the decoded outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= HOLD;
      hold_q    <= HoldLoad;
      rst_cnt_q <= '0;
      rstn_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rst_cnt_q <= rst_cnt_d;
      rstn_q    <= (state_d == RUN);
      busy_q    <= (state_d == HOLD);
    end
  end

  assign watchdog_rstn = rstn_q;
  assign wd_rst_busy   = busy_q;
  assign wd_rst_cnt    = rst_cnt_q;

endmodule

// File: doc/subsys_clkrst_ctrl.md
# subsys_clkrst_ctrl

Synthesizable clock-enable and watchdog-reset controller for the timer subsystem. It generates the `dualtimer_clken1`, `dualtimer_clken2`, `watchdog_clken` and `watchdog_rstn` signals that the timer peripherals consume; until now the bench drove these directly. It sequences the watchdog's local reset from `watchdog_res` and keeps a saturating count of watchdog-initiated resets. It sits beside the timer, dualtimer and watchdog in the subsystem top, all in the PCLK domain.

## Interface
- DIV_W, 8: width of every divider setting and counter.
- RST_HOLD, 16: cycles `watchdog_rstn` is held low per reset event; must be at least 1.
- CNT_W, 8: width of the reset-event counter.
- PCLK  in  1  sole clock, shared with the whole subsystem.
- PRESET  in  1  reset, synchronous, active-high; sampled on rising PCLK.
- dt_en1  in  1  enable for the dualtimer channel 1 clock enable.
- dt_en2  in  1  enable for the dualtimer channel 2 clock enable.
- wd_en  in  1  enable for the watchdog clock enable.
- dt_div1  in  DIV_W  channel 1 divide value; period is dt_div1+1 cycles.
- dt_div2  in  DIV_W  channel 2 divide value; period is dt_div2+1 cycles.
- wd_div  in  DIV_W  watchdog divide value; period is wd_div+1 cycles.
- watchdog_res  in  1  reset request from the watchdog, level.
- dualtimer_clken1  out  1  single-cycle enable pulse.
- dualtimer_clken2  out  1  single-cycle enable pulse.
- watchdog_clken  out  1  single-cycle enable pulse.
- watchdog_rstn  out  1  active-low watchdog reset, registered.
- wd_rst_cnt  out  CNT_W  number of watchdog-initiated resets, saturating.
- wd_rst_busy  out  1  high while in HOLD.

## Operation
- Divider (same for each of the three channels):
  - The counter `cnt` is reset to 0.
  - While the channel enable is low: cnt=0, output 0.
  - While enabled, each cycle: if cnt >= div then output pulses 1 and cnt←0; otherwise output 0 and cnt←cnt+1.
  - div=0 gives an output that is continuously high.
  - A new div takes effect immediately. If div drops below cnt, the pulse fires on the next cycle.
- Watchdog divider: additionally forced idle (cnt=0, no pulse) while state≠RUN.
- Reset FSM states: HOLD, RUN.
  - PRESET sends the FSM to HOLD with hold_cnt←RST_HOLD-1.
  - HOLD: `watchdog_rstn`=0 and `wd_rst_busy`=1. hold_cnt decrements each cycle; at hold_cnt==0 the FSM goes to RUN.
  - RUN: `watchdog_rstn`=1. A rising edge of `watchdog_res` (registered previous value 0, current value 1) sends the FSM to HOLD with hold_cnt←RST_HOLD-1, and increments `wd_rst_cnt` (saturates at all-ones).
  - A `watchdog_res` level held high does not retrigger. Edges seen during HOLD are ignored and not counted.
- The previous-value register for `watchdog_res` resets to 1. This prevents a spurious edge if the input is already high out of reset.

## Timing
- Reset values: all clken outputs 0; `watchdog_rstn` 0; `wd_rst_busy` 1; `wd_rst_cnt` 0; all divider counters 0.
- Once PRESET deasserts, `watchdog_rstn` stays 0 for exactly RST_HOLD cycles, then goes 1.
- Divider latency:
  - An enable rising in cycle N gives the first pulse registered at the end of cycle N+div (cnt starts at 0).
  - Pulses then repeat every div+1 cycles.
  - An enable falling in cycle N means no pulse from cycle N+1 onward.
- Watchdog-reset latency: a `watchdog_res` rising edge sampled at edge E drives `watchdog_rstn` low after edge E+1. The low phase lasts exactly RST_HOLD cycles.
- `wd_rst_cnt` updates at the same edge as the HOLD entry.
- PRESET asserted mid-operation overrides everything: HOLD is reloaded, counters clear, and the count is cleared.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `subsys_clkrst_pkg` holds:
  - the `rst_state_e` enum {HOLD, RUN};
  - the default DIV_W, RST_HOLD and CNT_W localparams.
- Sub-module `clken_div` (parameter DIV_W; ports PCLK, PRESET, en, force_idle, div, clken) is instantiated three times.
- The FSM, edge detector and counter live in the top module.

## Test plan
- Reset release, RST_HOLD=16: `watchdog_rstn` low for 16 cycles after PRESET falls, then high. `wd_rst_busy` falls at the same edge. All clkens stay 0 while disabled.
- dt_en1=1, dt_div1=3: `dualtimer_clken1` pulses every 4 cycles, first pulse 3 cycles after enable. dt_div2=0 with dt_en2=1 gives constant high.
- Retarget dt_div1 from 9 to 2 while cnt=6: pulse on the next cycle, then period 3.
- `watchdog_res` 0→1 held for 40 cycles during RUN: exactly one 16-cycle low pulse on `watchdog_rstn`; `wd_rst_cnt` 0→1. `watchdog_clken` is absent during HOLD and resumes wd_div+1 cycles after RUN.
- Second `watchdog_res` edge issued inside HOLD: ignored and count unchanged. Then 300 edges with CNT_W=8: count saturates at 255.
- PRESET pulsed mid-HOLD and mid-divide: every output returns to its reset value on the next edge, and a full 16-cycle hold restarts.
